// File: rtl/prog_loader_if.sv
// prog_loader_if -- byte-stream input and program-memory write port of the
// program loader.
//
// Signals:
//   in_valid   host -> loader   in_data holds a byte
//   in_data    host -> loader   stream byte
//   in_ready   loader -> host   loader accepts a byte this cycle
//   mem_we     loader -> memory write strobe
//   mem_addr   loader -> memory write address (ADDR_WIDTH)
//   mem_wdata  loader -> memory write data (INSTR_WIDTH)
//
// Modports: slave = the loader, master = the host/bench side.
interface prog_loader_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 11
);
  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_ready;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INSTR_WIDTH-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader -- downloads a program frame from a byte stream into the
// instruction memory and releases the core once the frame is complete.
//
// Frame: HEADER, COUNT (0 = 256 words), COUNT x {LO, HI}, optional CSUM.
//
// Ports:
//   clk        single clock, all state updates on posedge
//   reset      synchronous, active-high
//   bus        prog_loader_if.slave: byte stream in, memory write port out
//   cpu_run    1 = core may fetch/execute, 0 = core held
//   load_done  one-cycle pulse on successful frame completion
//   error      frame rejected; held until next header or reset
//
// Build option: define PROG_LOADER_CHECKSUM_EN to require a trailing
// checksum byte (COUNT + all LO/HI bytes + CSUM == 0 mod 256).
module prog_loader #(
  parameter int         ADDR_WIDTH  = 8,
  parameter int         INSTR_WIDTH = 11,
  parameter logic [7:0] HEADER      = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      bus,
  output logic              cpu_run,
  output logic              load_done,
  output logic              error
);

  // Number of instruction bits carried in the HI byte.
  localparam int HI_BITS = INSTR_WIDTH - 8;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_LO, S_HI, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                 state_r, state_n;
  logic [ADDR_WIDTH-1:0]  cnt_r, cnt_n;       // word counter, doubles as mem_addr
  logic [ADDR_WIDTH-1:0]  num_r, num_n;       // frame word count (0 = full memory)
  logic [7:0]             lo_r, lo_n;
  logic                   mem_we_r, mem_we_n;
  logic [INSTR_WIDTH-1:0] wdata_r, wdata_n;
  logic                   cpu_run_r, cpu_run_n;
  logic                   load_done_r, load_done_n;
  logic                   error_r, error_n;
  logic [ADDR_WIDTH-1:0]  cnt_inc;
  logic                   take;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]             sum_r, sum_n;
`endif

  // The only non-accepting state is WRITE, so the host sees one bubble per word.
  assign bus.in_ready  = ~reset & (state_r != S_WRITE);
  assign take          = bus.in_valid & bus.in_ready;
  assign cnt_inc       = cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = cnt_r;
  assign bus.mem_wdata = wdata_r;
  assign cpu_run       = cpu_run_r;
  assign load_done     = load_done_r;
  assign error         = error_r;

  // State and output registers; reset cancels any write in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      num_r       <= '0;
      lo_r        <= 8'h00;
      mem_we_r    <= 1'b0;
      wdata_r     <= '0;
      cpu_run_r   <= 1'b0;
      load_done_r <= 1'b0;
      error_r     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_r       <= 8'h00;
`endif
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      num_r       <= num_n;
      lo_r        <= lo_n;
      mem_we_r    <= mem_we_n;
      wdata_r     <= wdata_n;
      cpu_run_r   <= cpu_run_n;
      load_done_r <= load_done_n;
      error_r     <= error_n;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_r       <= sum_n;
`endif
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every output comes straight from a register.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    num_n       = num_r;
    lo_n        = lo_r;
    mem_we_n    = 1'b0;
    wdata_n     = wdata_r;
    cpu_run_n   = cpu_run_r;
    load_done_n = 1'b0;
    error_n     = error_r;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_n       = sum_r;
`endif

    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        // Non-header bytes are discarded; a header always starts a new load.
        if (take && (bus.in_data == HEADER)) begin
          state_n   = S_COUNT;
          cpu_run_n = 1'b0;
          error_n   = 1'b0;
        end else begin
          state_n   = state_r;
        end
      end

      S_COUNT: begin
        if (take) begin
          num_n   = ADDR_WIDTH'(bus.in_data);
          cnt_n   = '0;
          state_n = S_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_n   = bus.in_data;
`endif
        end else begin
          state_n = S_COUNT;
        end
      end

      S_LO: begin
        if (take) begin
          lo_n    = bus.in_data;
          state_n = S_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_n   = sum_r + bus.in_data;
`endif
        end else begin
          state_n = S_LO;
        end
      end

      S_HI: begin
        if (take) begin
          if (bus.in_data[7:HI_BITS] != '0) begin
            state_n   = S_ERR;
            error_n   = 1'b1;
            cpu_run_n = 1'b0;
          end else begin
            state_n   = S_WRITE;
            mem_we_n  = 1'b1;
            wdata_n   = {bus.in_data[HI_BITS-1:0], lo_r};
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_n = sum_r + bus.in_data;
`endif
        end else begin
          state_n = S_HI;
        end
      end

      S_WRITE: begin
        // Counter wraps naturally, so COUNT=0 ends after the 256th word.
        cnt_n = cnt_inc;
        if (cnt_inc == num_r) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_n     = S_CSUM;
`else
          state_n     = S_DONE;
          cpu_run_n   = 1'b1;
          load_done_n = 1'b1;
`endif
        end else begin
          state_n = S_LO;
        end
      end

      S_CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (take) begin
          if ((sum_r + bus.in_data) == 8'h00) begin
            state_n     = S_DONE;
            cpu_run_n   = 1'b1;
            load_done_n = 1'b1;
          end else begin
            state_n = S_ERR;
            error_n = 1'b1;
          end
        end else begin
          state_n = S_CSUM;
        end
`else
        state_n = S_IDLE;
`endif
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
